// File: rtl/mgmt_sram_wb_bridge_if.sv
// ---------------------------------------------------------------------------
// mgmt_sram_wb_bridge_if
//
// Bundles every bus-level signal of the management SRAM bridge:
//   - Wishbone slave side   : wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i,
//                             wb_dat_i (in) / wb_dat_o, wb_ack_o (out)
//   - read-only request port: ro_req, ro_addr (in) / ro_busy, ro_data,
//                             ro_valid (out)
//   - RAM macro pins        : mem_ena, mem_wen, mem_addr, mem_wdata (out) /
//                             mem_rdata (in)
//
// The "slave" modport is the bridge's view. The "master" modport is the
// view of everything around the bridge: the Wishbone master, the housekeeping
// requester and the RAM macro that returns mem_rdata.
// ---------------------------------------------------------------------------
interface mgmt_sram_wb_bridge_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // Wishbone
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;

  // Read-only request port
  logic          ro_req;
  logic [AW-1:0] ro_addr;
  logic          ro_busy;
  logic [DW-1:0] ro_data;
  logic          ro_valid;

  // RAM macro
  logic          mem_ena;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o,
    input  ro_req, ro_addr,
    output ro_busy, ro_data, ro_valid,
    output mem_ena, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o,
    output ro_req, ro_addr,
    input  ro_busy, ro_data, ro_valid,
    input  mem_ena, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mgmt_sram_wb_bridge.sv
// ---------------------------------------------------------------------------
// mgmt_sram_wb_bridge
//
// Wishbone-slave front-end for the management SoC's 256x32 single-port
// DFFRAM, plus a single-word read-only request port used by housekeeping
// read-back. The two requesters are arbitrated round-robin onto the RAM.
//
// Ports:
//   core_clk  - system clock, rising edge
//   core_rst  - asynchronous active-high reset
//   bus       - mgmt_sram_wb_bridge_if.slave: Wishbone slave signals,
//               read-only request port and RAM macro pins
//
// Timing (cycle 0 = grant cycle, RAM enabled combinationally):
//   WB write : ack in cycle 1
//   WB read  : ack + data in cycle 2
//   RO read  : ro_valid + ro_data in cycle 2 (a new grant may share cycle 2)
// ---------------------------------------------------------------------------
module mgmt_sram_wb_bridge #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  mgmt_sram_wb_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACK  = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    RO_WAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          ro_pend_q, ro_pend_d;
  logic [AW-1:0] ro_addr_q, ro_addr_d;
  logic          last_ro_q, last_ro_d;   // 1 = last grant went to the RO port
  logic [DW-1:0] wb_dat_q, wb_dat_d;
  logic          wb_ack_q, wb_ack_d;
  logic [DW-1:0] ro_data_q, ro_data_d;
  logic          ro_valid_q, ro_valid_d;

  logic          wb_req;
  logic          grant_wb;
  logic          grant_ro;
  logic          ro_busy;

  logic          mem_ena;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // Only the word index of the byte address selects a RAM word.
  logic unused_adr;
  assign unused_adr = ^{bus.wb_adr_i[31:AW+2], bus.wb_adr_i[1:0]};

  assign wb_req  = bus.wb_cyc_i & bus.wb_stb_i;
  assign ro_busy = ro_pend_q | (state_q == RO_WAIT);

  // Arbitration. Requests are looked at only in IDLE, so a strobe still held
  // high during the ack cycle can never start a second access.
  always_comb begin
    grant_wb = 1'b0;
    grant_ro = 1'b0;
    if (state_q == IDLE) begin
      if (wb_req && ro_pend_q) begin
        grant_wb = last_ro_q;
        grant_ro = ~last_ro_q;
      end else begin
        grant_wb = wb_req;
        grant_ro = ro_pend_q;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ro_pend_d  = ro_pend_q;
    ro_addr_d  = ro_addr_q;
    last_ro_d  = last_ro_q;
    wb_dat_d   = wb_dat_q;
    wb_ack_d   = 1'b0;
    ro_data_d  = ro_data_q;
    ro_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_wb) begin
          last_ro_d = 1'b0;
          if (bus.wb_we_i) begin
            state_d  = WR_ACK;
            wb_ack_d = 1'b1;       // ack lands in cycle 1
          end else begin
            state_d  = RD_WAIT;
          end
        end else if (grant_ro) begin
          last_ro_d = 1'b1;
          ro_pend_d = 1'b0;
          state_d   = RO_WAIT;
        end
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        wb_dat_d = bus.mem_rdata;
        wb_ack_d = 1'b1;           // ack with data lands in cycle 2
        state_d  = RD_ACK;
      end
      RD_ACK: begin
        state_d = IDLE;
      end
      RO_WAIT: begin
        ro_data_d  = bus.mem_rdata;
        ro_valid_d = 1'b1;
        state_d    = IDLE;         // RAM is free again in cycle 2
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A grant needs ro_pend_q=1, which makes ro_busy=1, so capture and
    // clear never coincide.
    if (bus.ro_req && !ro_busy) begin
      ro_pend_d = 1'b1;
      ro_addr_d = bus.ro_addr;
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q    <= IDLE;
      ro_pend_q  <= 1'b0;
      last_ro_q  <= 1'b1;
      wb_dat_q   <= '0;
      wb_ack_q   <= 1'b0;
      ro_data_q  <= '0;
      ro_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ro_pend_q  <= ro_pend_d;
      last_ro_q  <= last_ro_d;
      wb_dat_q   <= wb_dat_d;
      wb_ack_q   <= wb_ack_d;
      ro_data_q  <= ro_data_d;
      ro_valid_q <= ro_valid_d;
    end
  end

  // The latched address is only used while ro_pend_q is set, so it needs
  // no reset.
  always_ff @(posedge core_clk) begin
    ro_addr_q <= ro_addr_d;
  end

  // RAM pins are driven only in the grant cycle and forced quiet in reset so
  // an aborted transfer never reaches the macro.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!core_rst) begin
      if (grant_wb) begin
        mem_ena   = 1'b1;
        mem_addr  = bus.wb_adr_i[AW+1:2];
        mem_wen   = bus.wb_we_i ? bus.wb_sel_i : 4'b0000;
        mem_wdata = bus.wb_dat_i;
      end else if (grant_ro) begin
        mem_ena   = 1'b1;
        mem_addr  = ro_addr_q;
      end
    end
  end

  assign bus.mem_ena   = mem_ena;
  assign bus.mem_wen   = mem_wen;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.wb_dat_o  = wb_dat_q;
  assign bus.wb_ack_o  = wb_ack_q;
  assign bus.ro_busy   = ro_busy;
  assign bus.ro_data   = ro_data_q;
  assign bus.ro_valid  = ro_valid_q;

endmodule

// File: tb/tb_mgmt_sram_wb_bridge.sv
module tb_mgmt_sram_wb_bridge;
  localparam int AW = 8;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;
  always #5 core_clk = ~core_clk;

  mgmt_sram_wb_bridge_if #(.AW(AW), .DW(32)) bus ();

  mgmt_sram_wb_bridge #(.AW(AW), .DW(32)) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // RAM macro model: registered read, byte-lane write, read-before-write.
  logic [31:0] ram [256];
  always @(posedge core_clk) begin
    if (bus.mem_ena === 1'b1) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // Reference memory contents and scoreboard queues.
  logic [31:0] shadow [256];
  logic [31:0] wb_exp_q [$];
  logic [31:0] ro_exp_q [$];

  // Record every RAM grant address while enabled.
  logic log_en = 1'b0;
  logic [AW-1:0] grant_log [$];
  always @(negedge core_clk)
    if (log_en && bus.mem_ena === 1'b1) grant_log.push_back(bus.mem_addr);

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic shadow_write(input int w, input logic [3:0] sel, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (sel[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
  endtask

  // Drives one Wishbone transfer; the master holds stb through the ack cycle.
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdata, output int lat,
                         output int ena_cnt, output logic [3:0] wen0, output logic [AW-1:0] addr0,
                         output logic [31:0] wd0, output logic to);
    logic seen;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_sel_i = sel;  bus.wb_adr_i = adr;  bus.wb_dat_i = dat;
    to = 1'b1; lat = 0; ena_cnt = 0; seen = 1'b0;
    wen0 = '0; addr0 = '0; wd0 = '0; rdata = '0;
    for (int i = 0; i < 12 && to; i++) begin
      @(negedge core_clk);
      if (bus.mem_ena === 1'b1) begin
        if (!seen) begin
          wen0 = bus.mem_wen; addr0 = bus.mem_addr; wd0 = bus.mem_wdata; seen = 1'b1;
        end
        if (bus.mem_addr === adr[AW+1:2]) ena_cnt++;
      end
      if (bus.wb_ack_o === 1'b1) begin
        rdata = bus.wb_dat_o; lat = i; to = 1'b0;
      end else begin
        tick();
      end
    end
    tick();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  // Pulses ro_req, then waits for ro_valid; lat counts from the cycle after the pulse.
  task automatic ro_read(input logic [AW-1:0] a, output logic [31:0] d, output int lat,
                         output logic to);
    bus.ro_req = 1'b1; bus.ro_addr = a;
    tick();
    bus.ro_req = 1'b0;
    to = 1'b1; lat = 0; d = '0;
    for (int i = 0; i < 12 && to; i++) begin
      @(negedge core_clk);
      if (bus.ro_valid === 1'b1) begin
        d = bus.ro_data; lat = i; to = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = 32'h10; bus.wb_dat_i = 32'h1234_5678; bus.ro_req = 1'b1; bus.ro_addr = 8'd3;
    core_rst = 1'b1;
    tick(); tick();
    @(negedge core_clk);
    n_tests++;
    if ({bus.wb_ack_o, bus.ro_valid, bus.ro_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ctrl: ack/valid/busy=%b want 000", {bus.wb_ack_o, bus.ro_valid, bus.ro_busy});
    end
    n_tests++;
    if ({bus.wb_dat_o, bus.ro_data} !== 64'd0) begin
      n_fail++; $display("FAIL rst_data: wb_dat_o=%h ro_data=%h want 0", bus.wb_dat_o, bus.ro_data);
    end
    n_tests++;
    if ({bus.mem_ena, bus.mem_wen, bus.mem_addr, bus.mem_wdata} !== 45'd0) begin
      n_fail++; $display("FAIL rst_mem: ena=%b wen=%h addr=%h wdata=%h want 0", bus.mem_ena, bus.mem_wen, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.ro_req = 1'b0;
    core_rst = 1'b0;
    @(negedge core_clk);
    n_tests++;
    if ({bus.ro_busy, bus.mem_ena, bus.wb_ack_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_release: busy/ena/ack=%b want 000", {bus.ro_busy, bus.mem_ena, bus.wb_ack_o});
    end
    tick();
  endtask

  task automatic test_wb_write();
    logic [31:0] rd, wd0; int lat, ena; logic [3:0] wen0; logic [AW-1:0] a0; logic to;
    wb_xfer(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, ena, wen0, a0, wd0, to);
    shadow_write(4, 4'hF, 32'hDEAD_BEEF);
    n_tests++;
    if (to || lat != 1) begin
      n_fail++; $display("FAIL wr_lat: timeout=%b lat=%0d want ack in cycle 1", to, lat);
    end
    n_tests++;
    if ({a0, wen0, wd0} !== {8'd4, 4'hF, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wr_pins: addr=%h wen=%h wdata=%h want 04 f deadbeef", a0, wen0, wd0);
    end
    n_tests++;
    if (ena != 1) begin
      n_fail++; $display("FAIL wr_ena_cnt: %0d enables want 1", ena);
    end
    @(negedge core_clk);
    n_tests++;
    if ({bus.wb_ack_o, bus.mem_ena} !== 2'b00) begin
      n_fail++; $display("FAIL wr_ack_once: ack/ena=%b in cycle 2 want 00", {bus.wb_ack_o, bus.mem_ena});
    end
    tick();
  endtask

  task automatic test_wb_read();
    logic [31:0] rd, wd0, exp; int lat, ena; logic [3:0] wen0; logic [AW-1:0] a0; logic to;
    wb_exp_q.push_back(shadow[4]);
    wb_xfer(1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, lat, ena, wen0, a0, wd0, to);
    exp = wb_exp_q.pop_front();
    n_tests++;
    if (to || lat != 2 || rd !== exp) begin
      n_fail++; $display("FAIL rd_word4: timeout=%b lat=%0d data=%h want lat 2 data %h", to, lat, rd, exp);
    end
    n_tests++;
    if (ena != 1 || wen0 !== 4'h0 || a0 !== 8'd4) begin
      n_fail++; $display("FAIL rd_no_reaccept: enables=%0d wen=%h addr=%h want 1 0 04", ena, wen0, a0);
    end
    @(negedge core_clk);
    n_tests++;
    if (bus.wb_dat_o !== exp || bus.wb_ack_o !== 1'b0 || bus.mem_ena !== 1'b0) begin
      n_fail++; $display("FAIL rd_hold: dat=%h ack=%b ena=%b want %h 0 0", bus.wb_dat_o, bus.wb_ack_o, bus.mem_ena, exp);
    end
    tick();
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, wd0, exp; int lat, ena; logic [3:0] wen0; logic [AW-1:0] a0; logic to;
    wb_xfer(1'b1, 4'h2, 32'h0000_0010, 32'h0000_AB00, rd, lat, ena, wen0, a0, wd0, to);
    shadow_write(4, 4'h2, 32'h0000_AB00);
    n_tests++;
    if (to || lat != 1 || wen0 !== 4'h2) begin
      n_fail++; $display("FAIL byte_wr: timeout=%b lat=%0d wen=%h want lat 1 wen 2", to, lat, wen0);
    end
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL dat_o_held_over_write: %h want deadbeef", rd);
    end
    // sel=0 write: RAM is enabled and the write acknowledged, nothing changes.
    wb_xfer(1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, rd, lat, ena, wen0, a0, wd0, to);
    n_tests++;
    if (to || lat != 1 || ena != 1 || wen0 !== 4'h0) begin
      n_fail++; $display("FAIL sel0_wr: timeout=%b lat=%0d enables=%0d wen=%h want lat 1, 1 enable, wen 0", to, lat, ena, wen0);
    end
    wb_exp_q.push_back(shadow[4]);
    wb_xfer(1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, lat, ena, wen0, a0, wd0, to);
    exp = wb_exp_q.pop_front();
    n_tests++;
    if (to || lat != 2 || rd !== exp) begin
      n_fail++; $display("FAIL byte_readback: timeout=%b lat=%0d data=%h want %h", to, lat, rd, exp);
    end
  endtask

  task automatic test_ro();
    logic [31:0] exp; int extra;
    bus.ro_req = 1'b1; bus.ro_addr = 8'd4;
    ro_exp_q.push_back(shadow[4]);
    @(negedge core_clk);
    n_tests++;
    if (bus.ro_busy !== 1'b0) begin
      n_fail++; $display("FAIL ro_busy_req_cycle: %b want 0", bus.ro_busy);
    end
    tick();
    bus.ro_req = 1'b1; bus.ro_addr = 8'd5;      // must be ignored: busy
    @(negedge core_clk);
    n_tests++;
    if ({bus.ro_busy, bus.mem_ena, bus.mem_addr, bus.mem_wen} !== {1'b1, 1'b1, 8'd4, 4'h0}) begin
      n_fail++; $display("FAIL ro_grant: busy=%b ena=%b addr=%h wen=%h want 1 1 04 0", bus.ro_busy, bus.mem_ena, bus.mem_addr, bus.mem_wen);
    end
    tick();
    bus.ro_req = 1'b1; bus.ro_addr = 8'd6;      // must be ignored: still busy
    @(negedge core_clk);
    n_tests++;
    if ({bus.ro_busy, bus.ro_valid, bus.mem_ena} !== 3'b100) begin
      n_fail++; $display("FAIL ro_wait: busy/valid/ena=%b want 100", {bus.ro_busy, bus.ro_valid, bus.mem_ena});
    end
    tick();
    bus.ro_req = 1'b0;
    @(negedge core_clk);
    exp = ro_exp_q.pop_front();
    n_tests++;
    if (bus.ro_valid !== 1'b1 || bus.ro_data !== exp) begin
      n_fail++; $display("FAIL ro_result: valid=%b data=%h want 1 %h", bus.ro_valid, bus.ro_data, exp);
    end
    n_tests++;
    if ({bus.ro_busy, bus.mem_ena} !== 2'b00) begin
      n_fail++; $display("FAIL ro_ignore_busy_req: busy/ena=%b want 00", {bus.ro_busy, bus.mem_ena});
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge core_clk);
      if (bus.ro_valid !== 1'b0 || bus.mem_ena !== 1'b0 || bus.ro_data !== exp) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL ro_after: %0d bad cycles (stray valid/enable or ro_data not held) want 0", extra);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd0, rod, exp; int lat, ena, rlat, base; logic [3:0] wen0;
    logic [AW-1:0] a0; logic to, rto;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, 4'hF, 32'((8 + i) * 4), 32'hA5A5_0000 + 32'(i), rd, lat, ena, wen0, a0, wd0, to);
      shadow_write(8 + i, 4'hF, 32'hA5A5_0000 + 32'(i));
      wb_xfer(1'b1, 4'hF, 32'((16 + i) * 4), 32'h5A5A_0000 + 32'(i), rd, lat, ena, wen0, a0, wd0, to);
      shadow_write(16 + i, 4'hF, 32'h5A5A_0000 + 32'(i));
    end
    // A lone RO read leaves the round-robin pointer on RO.
    ro_exp_q.push_back(shadow[16]);
    ro_read(8'd16, rod, rlat, rto);
    exp = ro_exp_q.pop_front();
    n_tests++;
    if (rto || rlat != 2 || rod !== exp) begin
      n_fail++; $display("FAIL ro_lone: timeout=%b lat=%0d data=%h want lat 2 data %h", rto, rlat, rod, exp);
    end
    tick();
    base = grant_log.size();
    log_en = 1'b1;
    for (int it = 0; it < 4; it++) begin
      wb_exp_q.push_back(shadow[8 + it]);
      ro_exp_q.push_back(shadow[16 + it]);
      fork
        begin
          tick();
          wb_xfer(1'b0, 4'hF, 32'((8 + it) * 4), 32'h0, rd, lat, ena, wen0, a0, wd0, to);
        end
        begin
          ro_read(8'(16 + it), rod, rlat, rto);
        end
      join
      tick();
      exp = wb_exp_q.pop_front();
      n_tests++;
      if (to || lat != 2 || rd !== exp) begin
        n_fail++; $display("FAIL b2b_wb[%0d]: timeout=%b lat=%0d data=%h want lat 2 data %h", it, to, lat, rd, exp);
      end
      exp = ro_exp_q.pop_front();
      n_tests++;
      if (rto || rlat != 5 || rod !== exp) begin
        n_fail++; $display("FAIL b2b_ro[%0d]: timeout=%b lat=%0d data=%h want lat 5 data %h", it, rto, rlat, rod, exp);
      end
    end
    log_en = 1'b0;
    n_tests++;
    if (grant_log.size() - base != 8) begin
      n_fail++; $display("FAIL b2b_grant_count: %0d grants want 8", grant_log.size() - base);
    end else begin
      for (int g = 0; g < 8; g++) begin
        n_tests++;
        if (grant_log[base + g] !== ((g % 2 == 0) ? 8'(8 + g / 2) : 8'(16 + g / 2))) begin
          n_fail++; $display("FAIL b2b_grant_order[%0d]: addr=%h want %h", g, grant_log[base + g], (g % 2 == 0) ? 8'(8 + g / 2) : 8'(16 + g / 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd, wd0, exp; int lat, ena, bad; logic [3:0] wen0; logic [AW-1:0] a0; logic to;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = 32'h10; bus.ro_req = 1'b1; bus.ro_addr = 8'd4;
    @(negedge core_clk);
    n_tests++;
    if (bus.mem_ena !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_grant: ena=%b want 1", bus.mem_ena);
    end
    tick();                                     // now in RD_WAIT
    bus.ro_req = 1'b0;
    @(negedge core_clk);
    n_tests++;
    if ({bus.ro_busy, bus.wb_ack_o} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_pre: busy/ack=%b want 10", {bus.ro_busy, bus.wb_ack_o});
    end
    #1 core_rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.wb_ack_o, bus.mem_ena, bus.ro_busy, bus.ro_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_now: ack/ena/busy/valid=%b want 0000", {bus.wb_ack_o, bus.mem_ena, bus.ro_busy, bus.ro_valid});
    end
    tick();
    @(negedge core_clk);
    n_tests++;
    if (bus.wb_ack_o !== 1'b0 || bus.mem_ena !== 1'b0 || bus.wb_dat_o !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_held: ack=%b ena=%b dat=%h want 0 0 0", bus.wb_ack_o, bus.mem_ena, bus.wb_dat_o);
    end
    tick();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick();
    core_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge core_clk);
      if ({bus.wb_ack_o, bus.ro_valid, bus.ro_busy, bus.mem_ena} !== 4'b0000) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rstmid_after: %0d cycles with ack/valid/busy/ena set want 0", bad);
    end
    wb_exp_q.push_back(shadow[4]);
    wb_xfer(1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, lat, ena, wen0, a0, wd0, to);
    exp = wb_exp_q.pop_front();
    n_tests++;
    if (to || lat != 2 || rd !== exp) begin
      n_fail++; $display("FAIL rstmid_retry: timeout=%b lat=%0d data=%h want lat 2 data %h", to, lat, rd, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0; bus.ro_req = 1'b0; bus.ro_addr = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    test_reset();
    test_wb_write();
    test_wb_read();
    test_byte_write();
    test_ro();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mgmt_sram_wb_bridge.md
Name: mgmt_sram_wb_bridge

Overview:
Wishbone-slave front-end for the management SoC's 256x32 DFFRAM. It sits between the core's internal Wishbone bus and the RAM macro's EN/WE[3:0]/A/Di/Do pins. It also serves a single-word read-only request port, used by housekeeping SRAM read-back. Both requesters are arbitrated onto the single-port RAM.

Parameters:
AW, 8, RAM word-address width (256 words).
DW, 32, data width; must be 32.

Ports:
core_clk  in  1  system clock; all logic rising-edge.
core_rst  in  1  reset, asynchronous, active-high.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe; the bus already qualifies it with the RAM address decode.
wb_we_i  in  1  1 = write.
wb_sel_i  in  4  byte lanes.
wb_adr_i  in  32  byte address; bits [AW+1:2] form the word index; other bits are ignored.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data, registered.
wb_ack_o  out  1  acknowledge, registered.
ro_req  in  1  single-cycle read request pulse.
ro_addr  in  AW  word address; sampled with ro_req.
ro_busy  out  1  a read-only request is pending or in flight.
ro_data  out  32  last read-only result; held until the next result.
ro_valid  out  1  one-cycle pulse when ro_data updates.
mem_ena  out  1  RAM enable.
mem_wen  out  4  RAM byte write enables.
mem_addr  out  AW  RAM word address.
mem_wdata  out  32  RAM write data.
mem_rdata  in  32  RAM read data; valid the cycle after an enabled read.

Behaviour:
- Reset values: wb_dat_o=0, wb_ack_o=0, ro_busy=0, ro_data=0, ro_valid=0, state=IDLE, ro_pend=0, last_grant=RO. The mem_* outputs are combinational and read 0 in reset.
- Reset mid-transfer aborts the transfer. ack and valid drop immediately and no RAM enable is issued; the master must retry.
- RO capture: when ro_req=1 and ro_pend=0, set ro_pend and latch ro_addr. An ro_req while ro_busy=1 is ignored. ro_busy = ro_pend OR (state==RO_WAIT).
- WB request: wb_cyc_i & wb_stb_i, sampled only in IDLE.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin).
  - last_grant updates on each grant.
- Grant cycle (cycle 0, IDLE only): mem_ena=1.
  - WB: mem_addr = wb_adr_i[AW+1:2]; mem_wen = we ? sel : 4'b0; mem_wdata = wb_dat_i.
  - RO: mem_addr = latched ro_addr; mem_wen = 0.
  - Outside a grant cycle: mem_ena=0 and mem_wen=0; mem_addr and mem_wdata are don't-care but are driven 0.
- States:
  - IDLE: WB write grant -> WR_ACK; WB read grant -> RD_WAIT; RO grant -> RO_WAIT (ro_pend cleared).
  - WR_ACK (cycle 1): wb_ack_o=1 -> IDLE.
  - RD_WAIT (cycle 1): wb_dat_o <= mem_rdata -> RD_ACK.
  - RD_ACK (cycle 2): wb_ack_o=1 -> IDLE.
  - RO_WAIT (cycle 1): ro_data <= mem_rdata; ro_valid=1 in cycle 2 -> IDLE. A new grant is allowed in cycle 2.
- Latency from grant:
  - WB write: ack in cycle 1.
  - WB read: ack with data in cycle 2.
  - RO read: ro_valid in cycle 2.
- No re-accept on held strobe: IDLE is entered only after the ack cycle, so the master's stb still high in its ack cycle is not re-accepted.
- A write with sel=0 still enables the RAM and is acknowledged; no byte is written.
- A WB master dropping cyc before ack: the transfer completes internally; ack is still pulsed and is ignored.
- wb_dat_o holds its value between reads.
- Worst-case wait for either requester is one foreign transaction (3 cycles).

Test Plan:
- WB write adr=0x0000_0010, dat=0xDEADBEEF, sel=0xF -> cycle 0: mem_ena=1, mem_addr=4, mem_wen=0xF; ack in cycle 1 only.
- WB read of word 4 (RAM model returns 0xDEADBEEF) -> ack in cycle 2 with wb_dat_o=0xDEADBEEF; no second mem_ena while stb is held through the ack cycle.
- Byte write sel=0x2, dat=0x0000AB00 to word 4 -> mem_wen=0x2; a subsequent read returns 0xDEADABEF.
- ro_req with ro_addr=4 while idle -> ro_busy rises; ro_valid pulses 2 cycles after grant with ro_data=0xDEADABEF; a second ro_req while busy is ignored.
- WB read and ro_req pending in the same cycle, repeated back-to-back 4 times -> grants alternate WB, RO, WB, RO; both sides see bounded latency of 5 cycles or less.
- Assert core_rst during RD_WAIT -> wb_ack_o=0 and mem_ena=0 immediately; after release state is IDLE and ro_busy=0.
